hazard_scoreboard_unit: RTL and testbench
=========================================

// Module: hazard_scoreboard_unit
// PURPOSE
//  Pipeline hazard controller for the 5-stage MIPS core, successor to the combinational hazard logic.
//  Adds a multi-cycle MUL/DIV busy scoreboard (HI/LO hazards), JR stall, and optional perf counters.
//  Sits beside the datapath: consumes D/E/M/W register tags, drives stall, flush and forward selects.
// PARAMETERS
//  REG_AW   5   register-tag width (2**REG_AW architectural regs; tag 0 is hard-zero)
//  MUL_LAT  4   cycles from mult issue in E to HI/LO valid (>=1)
//  DIV_LAT  32  cycles from div issue in E to HI/LO valid (>=MUL_LAT)
//  PERF_W   32  perf-counter width (HAZARD_PERF_EN only)
// PORTS
//  clk        in   1       core clock
//  reset      in   1       synchronous, active-high
//  branchD    in   1       D holds a compare-in-D branch
//  jrD        in   1       D holds jr/jalr (reads rsD in D)
//  mdstartD   in   1       D holds mult/multu/div/divu
//  mfhiloD    in   1       D holds mfhi/mflo
//  mdstartE   in   1       mult/div issuing in E this cycle
//  mdisdivE   in   1       E op is div (1) or mult (0)
//  rsD,rtD,rsE,rtE                 in 5 (REG_AW)  source tags
//  writeregE,writeregM,writeregW   in 5 (REG_AW)  destination tags
//  memtoregE,memtoregM             in 1  load in stage
//  regwriteE,regwriteM,regwriteW   in 1  stage writes the register file
//  StallF,StallD  out 1   hold PC / IF-ID register
//  FlushE         out 1   bubble into ID-EX
//  ForwardAD,ForwardBD  out 1   D-stage compare operand from M
//  ForwardAE,ForwardBE  out 2   E operand select (fwd_sel_t)
//  mdbusy   out 1   MUL/DIV unit occupied
//  mddone   out 1   1-cycle pulse: HI/LO written this cycle
// BEHAVIOUR
//  - Forward E: tag!=0 & tag==writeregM & regwriteM -> FWD_MEM(10); else tag==writeregW & regwriteW -> FWD_WB(01); else FWD_RF(00). M beats W.
//  - Forward D: ForwardAD = rsD!=0 & rsD==writeregM & regwriteM; BD same with rtD.
//  - lwstall = memtoregE & rtE!=0 & (rtE==rsD | rtE==rtD).
//  - brstall = branchD & ((regwriteE & writeregE!=0 & writeregE in {rsD,rtD}) | (memtoregM & writeregM!=0 & writeregM in {rsD,rtD})).
//  - jrstall: as brstall, using rsD only and jrD.
//  - mdstall = (mfhiloD | mdstartD) & (mdbusy | mdstartE).
//  - StallD = StallF = FlushE = lwstall|brstall|jrstall|mdstall; combinational, same cycle.
//  - Counter md_cnt, width $clog2(DIV_LAT+1). Idle = 0.
//    mdstartE & md_cnt==0 -> load (mdisdivE ? DIV_LAT : MUL_LAT); else md_cnt!=0 -> decrement.
//    mdbusy = (md_cnt!=0), registered-state derived. mddone registered: 1 on the cycle md_cnt goes 1->0.
//    HI/LO valid exactly LAT cycles after the issue cycle (mddone asserted that cycle).
//  - mdstartE while mdbusy: ignored (no reload); assertion fires. mdstall prevents this in legal flow.
//  - Reset (any cycle, incl. mid-divide): md_cnt=0, mdbusy=0, mddone=0, perf counters=0; no done pulse.
//  - Stall outputs depend only on inputs and md_cnt; during reset they follow the inputs with md_cnt=0.
// CONFIGURATION
//  HAZARD_PERF_EN defined: adds outputs stall_cyc, lw_stall_cyc, md_stall_cyc [PERF_W-1:0].
//    Each increments when StallD / lwstall / mdstall is 1; saturates at all-ones; cleared by reset.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  hazard_pkg: fwd_sel_t enum {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}; stall_cause_t; REG_ZERO.
//  Sub-module md_busy_counter (md_cnt load/decrement, mdbusy, mddone) instantiated once.
//  Forward/stall decode stays inline combinational.
// TESTING
//  1 rsE=rtE=8, writeregM=writeregW=8, regwriteM=regwriteW=1 -> ForwardAE=ForwardBE=10; regwriteM=0 -> 01.
//  2 tag 0 on all writes with regwrite=1 -> ForwardAE/BE=00, ForwardAD/BD=0, no stall.
//  3 memtoregE=1, rtE=9, rsD=9 -> StallF=StallD=FlushE=1 one cycle; rtE=0 -> no stall.
//  4 mult in E (MUL_LAT=4), mflo in D -> mdstall 4 cycles, mddone on cycle 4, release on cycle 5.
//  5 div issue (DIV_LAT=32), reset asserted at cycle 10 -> mdbusy=0 next edge, no mddone pulse.
//  6 HAZARD_PERF_EN, 3 lw stalls + 4 md stalls -> stall_cyc=7, lw=3, md=4; counter at max stays max.

Source files
------------

// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  // E-stage operand source select.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // Classification of the reason the front end is held.
  typedef enum logic [2:0] {
    CAUSE_NONE = 3'd0,
    CAUSE_LW   = 3'd1,
    CAUSE_BR   = 3'd2,
    CAUSE_JR   = 3'd3,
    CAUSE_MD   = 3'd4
  } stall_cause_t;

  // Architectural register 0 is hard-wired to zero and never carries a hazard.
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_scoreboard_unit_md_busy_counter.sv
// MUL/DIV occupancy counter: loads the op latency on issue, counts down to
// idle, and pulses mddone in the cycle HI/LO become valid.
import hazard_pkg::*;

module md_busy_counter #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic mdstartE,
  input  logic mdisdivE,
  output logic mdbusy,
  output logic mddone
);

  localparam int CW = $clog2(DIV_LAT + 1);

  logic [CW-1:0] md_cnt_q, md_cnt_d;
  logic          mddone_q, mddone_d;

  // Next count: a new issue is only accepted when idle; otherwise count down.
  // mddone is high while the count sits at 1, i.e. LAT cycles after issue.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (mdstartE && (md_cnt_q == '0)) begin
      md_cnt_d = mdisdivE ? CW'(DIV_LAT) : CW'(MUL_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CW'(1);
    end
    mddone_d = (md_cnt_d == CW'(1));
  end

  // Counter and done-pulse registers; reset abandons any op in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q <= '0;
      mddone_q <= 1'b0;
    end else begin
      md_cnt_q <= md_cnt_d;
      mddone_q <= mddone_d;
    end
  end

  assign mdbusy = (md_cnt_q != '0);
  assign mddone = mddone_q;

  // A second issue while occupied is dropped; mdstall should make it impossible.
  a_no_issue_while_busy : assert property (@(posedge clk) disable iff (reset)
    !(mdstartE && mdbusy));

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard controller for the 5-stage MIPS core: forwarding selects, load-use /
// branch / jr / MUL-DIV stalls, and the MUL/DIV busy scoreboard.
// Optional macro HAZARD_PERF_EN adds saturating stall performance counters.
import hazard_pkg::*;

module hazard_scoreboard_unit #(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
`ifdef HAZARD_PERF_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branchD,
  input  logic              jrD,
  input  logic              mdstartD,
  input  logic              mfhiloD,
  input  logic              mdstartE,
  input  logic              mdisdivE,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              memtoregE,
  input  logic              memtoregM,
  input  logic              regwriteE,
  input  logic              regwriteM,
  input  logic              regwriteW,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output fwd_sel_t          ForwardAE,
  output fwd_sel_t          ForwardBE,
  output logic              mdbusy,
  output logic              mddone
`ifdef HAZARD_PERF_EN
  , output logic [PERF_W-1:0] stall_cyc
  , output logic [PERF_W-1:0] lw_stall_cyc
  , output logic [PERF_W-1:0] md_stall_cyc
`endif
);

  localparam logic [REG_AW-1:0] ZERO = REG_AW'(REG_ZERO);

  logic lwstall, brstall, jrstall, mdstall, stall;

  // E-stage source select: the younger result in M wins over W.
  function automatic fwd_sel_t fwd_e(input logic [REG_AW-1:0] tag,
                                     input logic [REG_AW-1:0] wr_m,
                                     input logic              rw_m,
                                     input logic [REG_AW-1:0] wr_w,
                                     input logic              rw_w);
    if (tag == ZERO)                 return FWD_RF;
    else if (rw_m && (tag == wr_m))  return FWD_MEM;
    else if (rw_w && (tag == wr_w))  return FWD_WB;
    else                             return FWD_RF;
  endfunction

  md_busy_counter #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_busy (
    .clk      (clk),
    .reset    (reset),
    .mdstartE (mdstartE),
    .mdisdivE (mdisdivE),
    .mdbusy   (mdbusy),
    .mddone   (mddone)
  );

  // Combinational hazard decode; stalls act in the same cycle they are seen.
  always_comb begin
    lwstall = memtoregE && (rtE != ZERO) && ((rtE == rsD) || (rtE == rtD));
    brstall = branchD &&
              ((regwriteE && (writeregE != ZERO) &&
                ((writeregE == rsD) || (writeregE == rtD))) ||
               (memtoregM && (writeregM != ZERO) &&
                ((writeregM == rsD) || (writeregM == rtD))));
    jrstall = jrD &&
              ((regwriteE && (writeregE != ZERO) && (writeregE == rsD)) ||
               (memtoregM && (writeregM != ZERO) && (writeregM == rsD)));
    mdstall = (mfhiloD || mdstartD) && (mdbusy || mdstartE);
    stall   = lwstall || brstall || jrstall || mdstall;

    StallF    = stall;
    StallD    = stall;
    FlushE    = stall;
    ForwardAD = (rsD != ZERO) && (rsD == writeregM) && regwriteM;
    ForwardBD = (rtD != ZERO) && (rtD == writeregM) && regwriteM;
    ForwardAE = fwd_e(rsE, writeregM, regwriteM, writeregW, regwriteW);
    ForwardBE = fwd_e(rtE, writeregM, regwriteM, writeregW, regwriteW);
  end

`ifdef HAZARD_PERF_EN
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v,
                                                input logic              en);
    if (en && (v != '1)) return v + PERF_W'(1);
    return v;
  endfunction

  logic [PERF_W-1:0] stall_cyc_q, stall_cyc_d;
  logic [PERF_W-1:0] lw_stall_cyc_q, lw_stall_cyc_d;
  logic [PERF_W-1:0] md_stall_cyc_q, md_stall_cyc_d;

  // Saturating event counts for each stall class.
  always_comb begin
    stall_cyc_d    = sat_inc(stall_cyc_q, stall);
    lw_stall_cyc_d = sat_inc(lw_stall_cyc_q, lwstall);
    md_stall_cyc_d = sat_inc(md_stall_cyc_q, mdstall);
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cyc_q    <= '0;
      lw_stall_cyc_q <= '0;
      md_stall_cyc_q <= '0;
    end else begin
      stall_cyc_q    <= stall_cyc_d;
      lw_stall_cyc_q <= lw_stall_cyc_d;
      md_stall_cyc_q <= md_stall_cyc_d;
    end
  end

  assign stall_cyc    = stall_cyc_q;
  assign lw_stall_cyc = lw_stall_cyc_q;
  assign md_stall_cyc = md_stall_cyc_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Scoreboard bench for hazard_scoreboard_unit: the stimulus thread queues the
// expected output vector per cycle, the monitor pops and compares at negedge.
`timescale 1ns/1ps
module tb_hazard_scoreboard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       branchD, jrD, mdstartD, mfhiloD, mdstartE, mdisdivE;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       memtoregE, memtoregM, regwriteE, regwriteM, regwriteW;
  logic       StallF, StallD, FlushE, ForwardAD, ForwardBD, mdbusy, mddone;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cyc, lw_stall_cyc, md_stall_cyc;
`endif

  hazard_scoreboard_unit dut (
    .clk(clk), .reset(reset), .branchD(branchD), .jrD(jrD),
    .mdstartD(mdstartD), .mfhiloD(mfhiloD), .mdstartE(mdstartE), .mdisdivE(mdisdivE),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mdbusy(mdbusy), .mddone(mddone)
`ifdef HAZARD_PERF_EN
    , .stall_cyc(stall_cyc), .lw_stall_cyc(lw_stall_cyc), .md_stall_cyc(md_stall_cyc)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [10:0] v;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // {StallF,StallD,FlushE,ForwardAD,ForwardBD,ForwardAE,ForwardBE,mdbusy,mddone}
  function automatic logic [10:0] ev(bit st, bit fad, bit fbd, logic [1:0] fae,
                                     logic [1:0] fbe, bit busy, bit done);
    return {st, st, st, fad, fbd, fae, fbe, busy, done};
  endfunction

  task automatic expect_now(string n, logic [10:0] v);
    exp_t e;
    e.cyc = cyc; e.v = v; e.name = n;
    q.push_back(e);
  endtask

  task automatic clr();
    branchD = 0; jrD = 0; mdstartD = 0; mfhiloD = 0; mdstartE = 0; mdisdivE = 0;
    rsD = 0; rtD = 0; rsE = 0; rtE = 0; writeregE = 0; writeregM = 0; writeregW = 0;
    memtoregE = 0; memtoregM = 0; regwriteE = 0; regwriteM = 0; regwriteW = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Monitor: compare every queued expectation in the cycle it was issued for.
  initial begin
    exp_t        e;
    logic [10:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e   = q.pop_front();
        act = {StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE, mdbusy, mddone};
        n_cmp++;
        if (e.cyc != cyc || act !== e.v) begin
          n_bad++;
          $display("FAIL %s (cyc %0d): got %b expected %b", e.name, e.cyc, act, e.v);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    clr();
    tick(); tick();
    expect_now("reset_state", ev(0, 0, 0, 2'b00, 2'b00, 0, 0));
    tick(); reset = 1'b0;

    // Forwarding priority
    tick(); clr();
    rsE = 8; rtE = 8; writeregM = 8; writeregW = 8; regwriteM = 1; regwriteW = 1;
    expect_now("fwd_mem_beats_wb", ev(0, 0, 0, 2'b10, 2'b10, 0, 0));
    tick(); regwriteM = 0;
    expect_now("fwd_wb", ev(0, 0, 0, 2'b01, 2'b01, 0, 0));
    tick(); clr(); rsE = 8; rtE = 3; writeregW = 8; regwriteW = 1;
    expect_now("fwd_mixed", ev(0, 0, 0, 2'b01, 2'b00, 0, 0));

    // Register zero never forwards or stalls
    tick(); clr();
    regwriteE = 1; regwriteM = 1; regwriteW = 1; memtoregE = 1; memtoregM = 1; branchD = 1; jrD = 1;
    expect_now("tag_zero", ev(0, 0, 0, 2'b00, 2'b00, 0, 0));

    // D-stage forward
    tick(); clr(); rsD = 5; rtD = 6; writeregM = 5; regwriteM = 1;
    expect_now("fwd_ad", ev(0, 1, 0, 2'b00, 2'b00, 0, 0));
    tick(); writeregM = 6;
    expect_now("fwd_bd", ev(0, 0, 1, 2'b00, 2'b00, 0, 0));

    // Load-use stall
    tick(); clr(); memtoregE = 1; rtE = 9; rsD = 9;
    expect_now("lwstall", ev(1, 0, 0, 2'b00, 2'b00, 0, 0));
    tick(); rtE = 0;
    expect_now("lw_rt_zero", ev(0, 0, 0, 2'b00, 2'b00, 0, 0));
    tick(); rtE = 9; rsD = 1; rtD = 9;
    expect_now("lwstall_rt", ev(1, 0, 0, 2'b00, 2'b00, 0, 0));

    // Branch and jr stalls
    tick(); clr(); branchD = 1; rsD = 3; regwriteE = 1; writeregE = 3;
    expect_now("brstall_e", ev(1, 0, 0, 2'b00, 2'b00, 0, 0));
    tick(); clr(); branchD = 1; rtD = 4; memtoregM = 1; writeregM = 4;
    expect_now("brstall_m", ev(1, 0, 0, 2'b00, 2'b00, 0, 0));
    tick(); clr(); jrD = 1; rsD = 4; memtoregM = 1; writeregM = 4;
    expect_now("jrstall", ev(1, 0, 0, 2'b00, 2'b00, 0, 0));
    tick(); clr(); jrD = 1; rsD = 7; rtD = 4; regwriteE = 1; writeregE = 4;
    expect_now("jr_rt_ignored", ev(0, 0, 0, 2'b00, 2'b00, 0, 0));

    // Multiply: issue, then mflo waits for four busy cycles
    tick(); clr(); mdstartE = 1; mdisdivE = 0;
    expect_now("mul_issue", ev(0, 0, 0, 2'b00, 2'b00, 0, 0));
    for (int k = 1; k <= 5; k++) begin
      tick(); clr(); mfhiloD = 1;
      expect_now($sformatf("mul_k%0d", k), ev(k <= 4, 0, 0, 2'b00, 2'b00, k <= 4, k == 4));
    end

    // Full divide with mult in D held during issue
    tick(); clr(); mdstartE = 1; mdisdivE = 1; mdstartD = 1;
    expect_now("div_issue_mdstall", ev(1, 0, 0, 2'b00, 2'b00, 0, 0));
    for (int k = 1; k <= 33; k++) begin
      tick(); clr(); mfhiloD = 1;
      expect_now($sformatf("div_k%0d", k), ev(k <= 32, 0, 0, 2'b00, 2'b00, k <= 32, k == 32));
    end

    // Divide abandoned by reset at cycle 10
    tick(); clr(); mdstartE = 1; mdisdivE = 1;
    expect_now("div2_issue", ev(0, 0, 0, 2'b00, 2'b00, 0, 0));
    for (int k = 1; k <= 9; k++) begin
      tick(); clr();
      expect_now($sformatf("div2_k%0d", k), ev(0, 0, 0, 2'b00, 2'b00, 1, 0));
    end
    tick(); clr(); reset = 1'b1;
    for (int k = 11; k <= 45; k++) begin
      tick(); clr(); reset = 1'b0; mfhiloD = 1;
      expect_now($sformatf("div2_rst_k%0d", k), ev(0, 0, 0, 2'b00, 2'b00, 0, 0));
    end

`ifdef HAZARD_PERF_EN
    tick(); clr(); reset = 1'b1;
    tick(); reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(); clr(); memtoregE = 1; rtE = 9; rsD = 9;
      expect_now("perf_lw", ev(1, 0, 0, 2'b00, 2'b00, 0, 0));
    end
    tick(); clr(); mdstartE = 1;
    for (int k = 1; k <= 4; k++) begin
      tick(); clr(); mfhiloD = 1;
    end
    tick(); clr(); tick();
    n_cmp++;
    if (stall_cyc !== 32'd7 || lw_stall_cyc !== 32'd3 || md_stall_cyc !== 32'd4) begin
      n_bad++;
      $display("FAIL perf_counts: got %0d/%0d/%0d expected 7/3/4", stall_cyc, lw_stall_cyc, md_stall_cyc);
    end
`endif

    // Drain the scoreboard with a bounded wait
    tick(); clr();
    for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
    if (q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
